// File: rtl/el2_trace_buf.sv
// el2_trace_buf: multi-channel retirement trace buffer.
// Up to NCH retired records per cycle are compacted in program order into a
// DEPTH-entry FIFO and drained one per cycle over a valid/ready port. Groups
// that do not fit are dropped whole and counted in a saturating loss counter.
module el2_trace_buf #(
    parameter int NCH   = 2,
    parameter int DEPTH = 8,
    parameter int MODE  = 0,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     ovf_clr,
    input  logic [NCH-1:0]           trace_rv_i_valid_ip,
    input  logic [32*NCH-1:0]        trace_rv_i_insn_ip,
    input  logic [32*NCH-1:0]        trace_rv_i_address_ip,
    input  logic [NCH-1:0]           trace_rv_i_exception_ip,
    input  logic [5*NCH-1:0]         trace_rv_i_ecause_ip,
    input  logic [NCH-1:0]           trace_rv_i_interrupt_ip,
    input  logic [32*NCH-1:0]        trace_rv_i_tval_ip,
    output logic                     trace_out_valid,
    input  logic                     trace_out_ready,
    output logic [31:0]              trace_out_insn,
    output logic [31:0]              trace_out_address,
    output logic [31:0]              trace_out_tval,
    output logic                     trace_out_exception,
    output logic                     trace_out_interrupt,
    output logic [4:0]               trace_out_ecause,
    output logic                     trace_stall,
    output logic                     ovf,
    output logic [CW-1:0]            drop_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int RW   = 103;

    // Record layout: {tval, address, insn, interrupt, ecause, exception}
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   mem_d [DEPTH];
    logic [RW-1:0]   rec   [NCH];
    logic [AW-1:0]   slot  [NCH];

    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CNTW-1:0] n_raw;
    logic [CNTW-1:0] n;
    logic [CNTW-1:0] free;
    logic            push;
    logic            drop;
    logic            pop;
    logic [CW-1:0]   drop_base;
    logic [CW:0]     drop_sum;
    logic [RW-1:0]   head;

    // Pack each channel's record and give every valid channel a gap-free slot
    always_comb begin
        n_raw = '0;
        for (int k = 0; k < NCH; k++) begin
            rec[k] = {trace_rv_i_tval_ip[32*k +: 32],
                      trace_rv_i_address_ip[32*k +: 32],
                      trace_rv_i_insn_ip[32*k +: 32],
                      trace_rv_i_interrupt_ip[k],
                      trace_rv_i_ecause_ip[5*k +: 5],
                      trace_rv_i_exception_ip[k]};
            slot[k] = wptr_q + n_raw[AW-1:0];
            if (trace_rv_i_valid_ip[k]) begin
                n_raw = n_raw + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
        n = en ? n_raw : '0;
    end

    // Decide push/drop/pop; room is judged before this cycle's pop
    always_comb begin
        free     = CNTW'(DEPTH) - count_q;
        push     = !flush && (n != '0) && (n <= free);
        drop     = !flush && (n > free);
        pop      = !flush && trace_out_valid && trace_out_ready;

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + n[AW-1:0];
            end
            if (pop) begin
                rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            count_d = count_q + (push ? n : '0) - (pop ? {{(CNTW-1){1'b0}}, 1'b1} : '0);
        end

        drop_base  = ovf_clr ? '0 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + (CW+1)'(n);
        ovf_d      = ovf_clr ? 1'b0 : ovf_q;
        drop_cnt_d = drop_base;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];
        end
    end

    // Write accepted records into their slots
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            mem_d[j] = mem_q[j];
        end
        if (push) begin
            for (int k = 0; k < NCH; k++) begin
                if (trace_rv_i_valid_ip[k]) begin
                    mem_d[slot[k]] = rec[k];
                end
            end
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            mem_q[j] <= mem_d[j];
        end
    end

    // Pointer, occupancy and loss-tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Present the head entry and status
    always_comb begin
        head                = mem_q[rptr_q];
        trace_out_valid     = (count_q != '0);
        trace_out_exception = head[0];
        trace_out_ecause    = head[5:1];
        trace_out_interrupt = head[6];
        trace_out_insn      = head[38:7];
        trace_out_address   = head[70:39];
        trace_out_tval      = head[102:71];
        trace_stall         = (MODE != 0) && (free < CNTW'(NCH));
        ovf                 = ovf_q;
        drop_cnt            = drop_cnt_q;
        count               = count_q;
    end

endmodule

// File: tb/tb_el2_trace_buf.sv
// tb_el2_trace_buf: directed stimulus with a scoreboard of expected addresses;
// a monitor pops and checks every record handed out on the trace port.
module tb_el2_trace_buf;

    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int MODE  = 1;
    localparam int CW    = 16;

    logic              clk;
    logic              rst;
    logic              en;
    logic              flush;
    logic              ovf_clr;
    logic [NCH-1:0]    v_ip;
    logic [32*NCH-1:0] insn_ip;
    logic [32*NCH-1:0] addr_ip;
    logic [NCH-1:0]    exc_ip;
    logic [5*NCH-1:0]  ecause_ip;
    logic [NCH-1:0]    int_ip;
    logic [32*NCH-1:0] tval_ip;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_insn;
    logic [31:0]       out_address;
    logic [31:0]       out_tval;
    logic              out_exception;
    logic              out_interrupt;
    logic [4:0]        out_ecause;
    logic              stall;
    logic              ovf;
    logic [CW-1:0]     drop_cnt;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;
    logic [31:0] sbQ [$];

    el2_trace_buf #(.NCH(NCH), .DEPTH(DEPTH), .MODE(MODE), .CW(CW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .en                      (en),
        .flush                   (flush),
        .ovf_clr                 (ovf_clr),
        .trace_rv_i_valid_ip     (v_ip),
        .trace_rv_i_insn_ip      (insn_ip),
        .trace_rv_i_address_ip   (addr_ip),
        .trace_rv_i_exception_ip (exc_ip),
        .trace_rv_i_ecause_ip    (ecause_ip),
        .trace_rv_i_interrupt_ip (int_ip),
        .trace_rv_i_tval_ip      (tval_ip),
        .trace_out_valid         (out_valid),
        .trace_out_ready         (out_ready),
        .trace_out_insn          (out_insn),
        .trace_out_address       (out_address),
        .trace_out_tval          (out_tval),
        .trace_out_exception     (out_exception),
        .trace_out_interrupt     (out_interrupt),
        .trace_out_ecause        (out_ecause),
        .trace_stall             (stall),
        .ovf                     (ovf),
        .drop_cnt                (drop_cnt),
        .count                   (count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record fields are derived from the address so one queue entry describes a whole record
    function automatic logic [31:0] insnOf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] tvalOf(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [6:0] flagsOf(input logic [31:0] a);
        return {a[3], a[6:2], a[2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of retirement on both channels, then return inputs to idle
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] a [2];
        a[0] = a0;
        a[1] = a1;
        v_ip = v;
        for (int k = 0; k < NCH; k++) begin
            addr_ip[32*k +: 32]  = a[k];
            insn_ip[32*k +: 32]  = insnOf(a[k]);
            tval_ip[32*k +: 32]  = tvalOf(a[k]);
            exc_ip[k]            = a[k][2];
            int_ip[k]            = a[k][3];
            ecause_ip[5*k +: 5]  = a[k][6:2];
        end
        @(posedge clk);
        #1;
        v_ip = '0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (count == 0) break;
            idleCycle();
        end
        checkOutput(name, 32'(count), 32'd0);
        checkOutput({name, "_sb"}, 32'(sbQ.size()), 32'd0);
    endtask

    // Monitor: every handshake must deliver the oldest expected record
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_pop", out_address, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = sbQ.pop_front();
                checkOutput("out_address", out_address, e);
                checkOutput("out_insn", out_insn, insnOf(e));
                checkOutput("out_tval", out_tval, tvalOf(e));
                checkOutput("out_flags", 32'({out_interrupt, out_ecause, out_exception}), 32'(flagsOf(e)));
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
        v_ip = '0; insn_ip = '0; addr_ip = '0; exc_ip = '0; ecause_ip = '0; int_ip = '0; tval_ip = '0;
        idleCycle();
        idleCycle();
        rst = 1'b0;

        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);

        // Single push then pop
        sbQ.push_back(32'h1000);
        applyStimulus(2'b01, 32'h1000, 32'h0);
        checkOutput("single_count", 32'(count), 32'd1);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_addr", out_address, 32'h1000);
        out_ready = 1'b1;
        idleCycle();
        checkOutput("single_pop_count", 32'(count), 32'd0);

        // Compaction: channel 1 alone, then both
        sbQ.push_back(32'h2004);
        applyStimulus(2'b10, 32'h0, 32'h2004);
        sbQ.push_back(32'h3000);
        sbQ.push_back(32'h3004);
        applyStimulus(2'b11, 32'h3000, 32'h3004);
        waitDrain("compact_drain");

        // Overflow: fill with ready low, fifth group dropped
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sbQ.push_back(32'h5000 + 32'(16*i));
            sbQ.push_back(32'h5004 + 32'(16*i));
            applyStimulus(2'b11, 32'h5000 + 32'(16*i), 32'h5004 + 32'(16*i));
            if (i == 2) checkOutput("stall_at6", 32'(stall), 32'd0);
        end
        checkOutput("full_stall", 32'(stall), 32'd1);
        applyStimulus(2'b11, 32'h5F00, 32'h5F04);
        checkOutput("ovf_count", 32'(count), 32'd8);
        checkOutput("ovf_drop", 32'(drop_cnt), 32'd2);
        checkOutput("ovf_flag", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        idleCycle();
        checkOutput("clr_drop", 32'(drop_cnt), 32'd0);
        checkOutput("clr_ovf", 32'(ovf), 32'd0);
        applyStimulus(2'b11, 32'h5E00, 32'h5E04);
        ovf_clr = 1'b0;
        checkOutput("clr_drop_same", 32'(drop_cnt), 32'd2);
        checkOutput("clr_ovf_same", 32'(ovf), 32'd1);

        // Full with ready high: pop proceeds, push dropped
        out_ready = 1'b1;
        applyStimulus(2'b01, 32'h5D00, 32'h0);
        out_ready = 1'b0;
        checkOutput("fullpop_count", 32'(count), 32'd7);
        checkOutput("fullpop_drop", 32'(drop_cnt), 32'd3);
        checkOutput("stall_at7", 32'(stall), 32'd1);
        out_ready = 1'b1;
        idleCycle();
        out_ready = 1'b0;
        checkOutput("pop_to6_count", 32'(count), 32'd6);
        checkOutput("stall_pop6", 32'(stall), 32'd0);
        out_ready = 1'b1;
        waitDrain("ovf_drain");

        // Wrap-around streaming
        for (int i = 0; i < 20; i++) begin
            sbQ.push_back(32'h4000 + 32'(4*i));
            applyStimulus(2'b01, 32'h4000 + 32'(4*i), 32'h0);
        end
        waitDrain("wrap_drain");
        checkOutput("wrap_drop", 32'(drop_cnt), 32'd3);

        // Flush with arrivals in the same cycle
        out_ready = 1'b0;
        applyStimulus(2'b11, 32'h7000, 32'h7004);
        applyStimulus(2'b11, 32'h7010, 32'h7014);
        applyStimulus(2'b01, 32'h7020, 32'h0);
        checkOutput("preflush_count", 32'(count), 32'd5);
        flush = 1'b1;
        applyStimulus(2'b11, 32'h7030, 32'h7034);
        flush = 1'b0;
        sbQ.delete();
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_drop", 32'(drop_cnt), 32'd3);
        sbQ.push_back(32'h6000);
        applyStimulus(2'b01, 32'h6000, 32'h0);
        checkOutput("postflush_addr", out_address, 32'h6000);

        // Reset mid-stream
        applyStimulus(2'b10, 32'h0, 32'h6004);
        checkOutput("prerst_count", 32'(count), 32'd2);
        rst = 1'b1;
        applyStimulus(2'b11, 32'h6100, 32'h6104);
        sbQ.delete();
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ovf", 32'(ovf), 32'd0);
        checkOutput("midrst_drop", 32'(drop_cnt), 32'd0);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
